// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, one shift-add or restoring
// shift-subtract step per cycle on operand magnitudes, sign-corrected at the end.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_REG    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] OpA,
  input  logic [DATA_WIDTH-1:0] OpB,
  input  logic [ADD_REG-1:0]    RdIn,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] Result,
  output logic [ADD_REG-1:0]    RdOut,
  output logic                  WbEn
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;
  typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;
  state_t r_state, w_next;
  logic [2:0]         r_op;
  logic               r_na, r_nb, r_bz;
  logic [W-1:0]       r_hi, r_lo, r_m, r_res;
  logic [ADD_REG-1:0] r_rd;
  logic [CW-1:0]      r_cnt;
  logic               w_sa, w_sb, w_na, w_nb, w_ge, w_last;
  logic [W-1:0]       w_ma, w_mb, w_quo, w_rem, w_res;
  logic [W:0]         w_sum, w_tmp, w_diff;
  logic [2*W-1:0]     w_prod, w_prod_s;
  assign w_sa   = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_sb   = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_na   = w_sa & OpA[W-1];
  assign w_nb   = w_sb & OpB[W-1];
  assign w_ma   = w_na ? -OpA : OpA;
  assign w_mb   = w_nb ? -OpB : OpB;
  assign w_last = r_cnt == CW'(W);
  // multiply: r_lo holds the multiplier and fills with product low bits; r_m is the multiplicand
  assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
  // divide: r_lo shifts the dividend out and quotient bits in; r_hi is the partial remainder
  assign w_tmp  = {r_hi, r_lo[W-1]};
  assign w_diff = w_tmp - {1'b0, r_m};
  assign w_ge   = ~w_diff[W];
  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = (r_na ^ r_nb) ? -w_prod : w_prod;
  assign w_quo    = r_bz ? '1 : ((r_na ^ r_nb) ? -r_lo : r_lo);
  assign w_rem    = r_na ? -r_hi : r_hi;
  assign w_res    = (r_op == 3'b000) ? w_prod_s[W-1:0] :
                    !r_op[2]         ? w_prod_s[2*W-1:W] :
                    !r_op[1]         ? w_quo : w_rem;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? CALC : IDLE;
      CALC:    w_next = w_last ? FIN : CALC;
      FIN:     w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op  <= '0;
      r_na  <= 1'b0;
      r_nb  <= 1'b0;
      r_bz  <= 1'b0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_m   <= '0;
      r_res <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (r_state == IDLE && start) begin
      r_op  <= funct3;
      r_rd  <= RdIn;
      r_na  <= w_na;
      r_nb  <= w_nb;
      r_bz  <= OpB == '0;
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= funct3[2] ? w_ma : w_mb;
      r_m   <= funct3[2] ? w_mb : w_ma;
    end else if (r_state == CALC && !w_last) begin
      r_cnt <= r_cnt + CW'(1);
      r_hi  <= r_op[2] ? (w_ge ? w_diff[W-1:0] : w_tmp[W-1:0]) : w_sum[W:1];
      r_lo  <= r_op[2] ? {r_lo[W-2:0], w_ge} : {w_sum[0], r_lo[W-1:1]};
    end else if (r_state == FIN) begin
      r_res <= w_res;
    end
  end
  assign busy   = r_state != IDLE;
  assign done   = r_state == DONE;
  assign Result = r_res;
  assign RdOut  = r_rd;
  assign WbEn   = done && (r_rd != '0);
endmodule
